// File: rtl/gfp_nv_accum.sv
// GFP native-vector K-dimension accumulator: aligns each NV result to the running max exponent and sums.
// Optional macro GFP_NV_ACCUM_SAT_EN: saturate every accumulation add to the ACC_W signed range.
`timescale 1ns/1ps
module gfp_nv_accum #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [CNT_W-1:0] i_nv_count,
   input  logic             i_valid,
   input  logic [31:0]      i_mantissa,
   input  logic [7:0]       i_exponent,
   output logic             o_ready,
   output logic             o_valid,
   output logic [ACC_W-1:0] o_mantissa,
   output logic [7:0]       o_exponent,
   input  logic             i_out_ready
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [8:0] SH_MAX = 9'(ACC_W - 1);

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_m_q, acc_m_d;
   logic signed [7:0]       acc_e_q, acc_e_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        tgt_q, tgt_d;

   logic                    accept;
   logic [CNT_W-1:0]        cnt_inc;
   logic signed [7:0]       in_e;
   logic signed [7:0]       e_new;
   logic [8:0]              d_acc, d_in;
   logic signed [ACC_W-1:0] in_ext, acc_sh, in_sh, raw_sum, sum;

   assign accept  = i_valid & o_ready;
   assign cnt_inc = cnt_q + 1'b1;
   assign in_e    = $signed(i_exponent);
   assign in_ext  = $signed({{(ACC_W-32){i_mantissa[31]}}, i_mantissa});

   // Alignment: shifts beyond the accumulator width flush the operand to zero.
   always_comb begin
      e_new  = (in_e > acc_e_q) ? in_e : acc_e_q;
      d_acc  = {e_new[7], e_new} - {acc_e_q[7], acc_e_q};
      d_in   = {e_new[7], e_new} - {in_e[7], in_e};
      acc_sh = '0;
      in_sh  = '0;
      if (d_acc <= SH_MAX) acc_sh = acc_m_q >>> d_acc;
      if (d_in <= SH_MAX)  in_sh  = in_ext >>> d_in;
      raw_sum = acc_sh + in_sh;
`ifdef GFP_NV_ACCUM_SAT_EN
      if ((acc_sh[ACC_W-1] == in_sh[ACC_W-1]) && (raw_sum[ACC_W-1] != acc_sh[ACC_W-1]))
         sum = acc_sh[ACC_W-1] ? $signed({1'b1, {(ACC_W-1){1'b0}}})
                               : $signed({1'b0, {(ACC_W-1){1'b1}}});
      else
         sum = raw_sum;
`else
      sum = raw_sum;
`endif
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         acc_m_q <= '0;
         acc_e_q <= '0;
         cnt_q   <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_m_q <= acc_m_d;
         acc_e_q <= acc_e_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_m_d = acc_m_q;
      acc_e_d = acc_e_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               tgt_d   = (i_nv_count == '0) ? CNT_W'(1) : i_nv_count;
               acc_m_d = in_ext;
               acc_e_d = in_e;
               cnt_d   = CNT_W'(1);
               state_d = (i_nv_count <= CNT_W'(1)) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_m_d = sum;
               acc_e_d = e_new;
               cnt_d   = cnt_inc;
               if (cnt_inc == tgt_q) state_d = DONE;
            end
         end
         DONE: begin
            if (i_out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_ready    = (state_q != DONE);
      o_valid    = (state_q == DONE);
      o_mantissa = acc_m_q;
      o_exponent = acc_e_q;
   end

endmodule

// File: tb/tb_gfp_nv_accum.sv
// Directed scoreboard bench for gfp_nv_accum: a 40-bit instance for the main flow and a 33-bit one for overflow.
`timescale 1ns/1ps
module tb_gfp_nv_accum;

   localparam int WA = 40;
   localparam int WB = 33;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]    a_cnt, b_cnt;
   logic          a_valid, b_valid;
   logic [31:0]   a_m, b_m;
   logic [7:0]    a_e, b_e;
   logic          a_rdy, b_rdy, a_ov, b_ov, a_ordy, b_ordy;
   logic [WA-1:0] a_om;
   logic [WB-1:0] b_om;
   logic [7:0]    a_oe, b_oe;

   gfp_nv_accum #(.ACC_W(WA), .CNT_W(8)) dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_nv_count(a_cnt), .i_valid(a_valid),
      .i_mantissa(a_m), .i_exponent(a_e), .o_ready(a_rdy), .o_valid(a_ov),
      .o_mantissa(a_om), .o_exponent(a_oe), .i_out_ready(a_ordy));

   gfp_nv_accum #(.ACC_W(WB), .CNT_W(8)) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_nv_count(b_cnt), .i_valid(b_valid),
      .i_mantissa(b_m), .i_exponent(b_e), .o_ready(b_rdy), .o_valid(b_ov),
      .o_mantissa(b_om), .o_exponent(b_oe), .i_out_ready(b_ordy));

   typedef struct {
      logic signed [63:0] m;
      logic signed [7:0]  e;
   } res_t;

   res_t   qa[$];
   res_t   qb[$];
   int     checks = 0;
   int     errors = 0;
   longint mdl_m;
   int     mdl_e;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrap(input longint s, input int w);
      longint md, lo;
      md = longint'(1) << w;
      lo = s & (md - 1);
      if (lo >= (md >>> 1)) lo = lo - md;
      return lo;
   endfunction

   function automatic void mdl_load(input int m, input int e);
      mdl_m = longint'(m);
      mdl_e = e;
   endfunction

   function automatic void mdl_acc(input int m, input int e, input int w);
      int     en;
      longint a, b, s;
      en = (e > mdl_e) ? e : mdl_e;
      a  = ((en - mdl_e) > w - 1) ? 0 : (mdl_m >>> (en - mdl_e));
      b  = ((en - e) > w - 1) ? 0 : (longint'(m) >>> (en - e));
      s  = a + b;
`ifdef GFP_NV_ACCUM_SAT_EN
      if (s > (longint'(1) << (w - 1)) - 1) s = (longint'(1) << (w - 1)) - 1;
      if (s < -(longint'(1) << (w - 1)))    s = -(longint'(1) << (w - 1));
`else
      s = wrap(s, w);
`endif
      mdl_m = s;
      mdl_e = en;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input int cnt, input int m, input int e, input bit first, input bit last);
      chk("send_ready", a_rdy, 1);
      a_cnt = 8'(cnt); a_m = 32'(m); a_e = 8'(e); a_valid = 1'b1;
      if (first) mdl_load(m, e); else mdl_acc(m, e, WA);
      if (last) qa.push_back('{m: mdl_m, e: 8'(mdl_e)});
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic collect(input string tag);
      res_t r;
      int   n;
      a_ordy = 1'b1;
      n = 0;
      @(negedge clk);
      while (!a_ov && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, a_ov, 1);
      if (qa.size() == 0) begin
         checks++; errors++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         r = qa.pop_front();
         chk({tag, "_m"}, $signed(a_om), r.m);
         chk({tag, "_e"}, $signed(a_oe), r.e);
      end
      @(posedge clk); #1;
      a_ordy = 1'b0;
      @(negedge clk);
      chk({tag, "_vld_drop"}, a_ov, 0);
      chk({tag, "_rdy_back"}, a_rdy, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      a_cnt = '0; a_valid = 0; a_m = '0; a_e = '0; a_ordy = 0;
      b_cnt = '0; b_valid = 0; b_m = '0; b_e = '0; b_ordy = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", a_ov, 0);
      chk("rst_m", $signed(a_om), 0);
      chk("rst_e", $signed(a_oe), 0);
      chk("rst_ready", a_rdy, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      send(1, 100, 5, 1, 1);
      @(negedge clk);
      chk("lat_valid", a_ov, 1);
      chk("lat_ready", a_rdy, 0);
      @(posedge clk); #1;
      chk("hold_valid", a_ov, 1);
      collect("cnt1");

      send(2, 64, 3, 1, 0);
      send(2, 64, 5, 0, 1);
      collect("cnt2");

      send(3, -8, 0, 1, 0);
      send(3, 4, 0, 0, 0);
      send(3, 3, 1, 0, 1);
      collect("cnt3");

      send(2, 0, 7, 1, 0);
      send(9, 16, 3, 0, 1);
      collect("zero_m_exp");

      send(0, 42, -3, 1, 1);
      collect("cnt0");

      send(2, -1000, 0, 1, 0);
      send(2, -5, 4, 0, 1);
      collect("neg");

      send(2, 1000, -60, 1, 0);
      send(2, 7, 10, 0, 1);
      collect("underflow");

      send(1, 5, 1, 1, 1);
      for (int i = 0; i < 5; i++) begin
         a_valid = 1'b1; a_m = 32'd999; a_e = 8'd2;
         @(negedge clk);
         chk("bp_valid", a_ov, 1);
         chk("bp_m", $signed(a_om), 5);
         chk("bp_ready", a_rdy, 0);
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
      collect("bp");
      send(1, 11, 0, 1, 1);
      collect("bp_fresh");

      b_cnt = 8'd3; b_m = 32'h7FFF_FFFF; b_e = 8'd0; b_valid = 1'b1;
      mdl_load(32'h7FFF_FFFF, 0);
      mdl_acc(32'h7FFF_FFFF, 0, WB);
      mdl_acc(32'h7FFF_FFFF, 0, WB);
      qb.push_back('{m: mdl_m, e: 8'(mdl_e)});
      repeat (3) @(posedge clk);
      #1;
      b_valid = 1'b0;
      @(negedge clk);
      chk("ovf_valid", b_ov, 1);
      r = qb.pop_front();
      chk("ovf_m", $signed(b_om), r.m);
`ifdef GFP_NV_ACCUM_SAT_EN
      chk("ovf_m_const", $signed(b_om), 64'sd4294967295);
`else
      chk("ovf_m_const", $signed(b_om), -64'sd2147483651);
`endif
      chk("ovf_e", $signed(b_oe), r.e);
      b_ordy = 1'b1;
      @(posedge clk); #1;
      b_ordy = 1'b0;
      @(negedge clk);
      chk("ovf_done", b_ov, 0);
      @(posedge clk); #1;

      send(3, 50, 2, 1, 0);
      chk("pre_rst_m", $signed(a_om), 50);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", a_ov, 0);
      chk("midrst_m", $signed(a_om), 0);
      chk("midrst_e", $signed(a_oe), 0);
      chk("midrst_ready", a_rdy, 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send(2, 3, 1, 1, 0);
      send(2, 5, 1, 0, 1);
      collect("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
